// File: rtl/csd_stage_ctrl.sv
// Two-stage control around an external CSD complex multiplier: registers the sample and
// coefficient select, then requantizes the product. Define CSD_STAGE_CTRL_SAT_EN for saturation.
module csd_stage_ctrl #(
  parameter int NBITS      = 12,
  parameter int NBITScoeff = 11,
  parameter int NBITS_out  = NBITS + NBITScoeff + 1,
  parameter int NPOINTS    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [2*NBITS-1:0]     in_data,
  output logic                   in_ready,
  output logic [2*NBITS-1:0]     muestra,
  output logic                   csd,
  input  logic [2*NBITS_out-1:0] result,
  output logic                   out_valid,
  output logic [2*NBITS-1:0]     out_data,
  input  logic                   out_ready,
  output logic                   frame_start,
  output logic                   sat_flag
);

  localparam int IW    = (NPOINTS > 2) ? $clog2(NPOINTS) : 1;
  localparam int RW    = NBITS_out + 1;
  localparam int SHIFT = NBITScoeff - 2;

  localparam logic [IW-1:0]        HALF = IW'(NPOINTS / 2);
  localparam logic signed [RW-1:0] RND  = RW'(1) << (NBITScoeff - 3);
  localparam logic signed [RW-1:0] SMAX = RW'((1 << (NBITS - 1)) - 1);
  localparam logic signed [RW-1:0] SMIN = -SMAX - RW'(1);

  logic                 w_adv;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_clip;

  logic signed [RW-1:0] w_sum_re;
  logic signed [RW-1:0] w_sum_im;
  logic signed [RW-1:0] w_sh_re;
  logic signed [RW-1:0] w_sh_im;
  logic                 w_hi_re;
  logic                 w_lo_re;
  logic                 w_hi_im;
  logic                 w_lo_im;
  logic [NBITS-1:0]     w_q_re;
  logic [NBITS-1:0]     w_q_im;

  logic [IW-1:0]        r_idx;
  logic                 r_s1_valid;
  logic                 r_s1_first;
  logic [2*NBITS-1:0]   r_muestra;
  logic                 r_csd;
  logic                 r_out_valid;
  logic [2*NBITS-1:0]   r_out_data;
  logic                 r_frame_start;
  logic                 r_sat;

  // Both stages move together; a stalled output freezes the whole pipe so the
  // multiplier operands stay put until stage 2 can take the product.
  assign w_adv     = ~r_out_valid | out_ready;
  assign in_ready  = w_adv & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign w_capture = w_adv & r_s1_valid;

  assign w_sum_re = $signed({result[2*NBITS_out-1], result[2*NBITS_out-1 -: NBITS_out]}) + RND;
  assign w_sum_im = $signed({result[NBITS_out-1], result[NBITS_out-1:0]}) + RND;
  assign w_sh_re  = w_sum_re >>> SHIFT;
  assign w_sh_im  = w_sum_im >>> SHIFT;

  assign w_hi_re = w_sh_re > SMAX;
  assign w_lo_re = w_sh_re < SMIN;
  assign w_hi_im = w_sh_im > SMAX;
  assign w_lo_im = w_sh_im < SMIN;

`ifdef CSD_STAGE_CTRL_SAT_EN
  always_comb begin
    w_q_re = w_sh_re[NBITS-1:0];
    w_q_im = w_sh_im[NBITS-1:0];
    if (w_hi_re)      w_q_re = SMAX[NBITS-1:0];
    else if (w_lo_re) w_q_re = SMIN[NBITS-1:0];
    if (w_hi_im)      w_q_im = SMAX[NBITS-1:0];
    else if (w_lo_im) w_q_im = SMIN[NBITS-1:0];
  end
  assign w_clip = w_hi_re | w_lo_re | w_hi_im | w_lo_im;
`else
  logic w_unused_clip;
  assign w_q_re        = w_sh_re[NBITS-1:0];
  assign w_q_im        = w_sh_im[NBITS-1:0];
  assign w_clip        = 1'b0;
  assign w_unused_clip = ^{w_hi_re, w_lo_re, w_hi_im, w_lo_im};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_muestra  <= '0;
      r_csd      <= 1'b1;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (w_accept) begin
        r_muestra  <= in_data;
        r_csd      <= (r_idx < HALF);
        r_s1_first <= (r_idx == '0);
        r_idx      <= r_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_frame_start <= 1'b0;
      r_sat         <= 1'b0;
    end else begin
      if (w_adv) begin
        r_out_valid   <= r_s1_valid;
        r_frame_start <= r_s1_valid & r_s1_first;
        if (r_s1_valid) r_out_data <= {w_q_re, w_q_im};
      end
      if (w_capture && w_clip) r_sat <= 1'b1;
    end
  end

  assign muestra     = r_muestra;
  assign csd         = r_csd;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign frame_start = r_frame_start;
  assign sat_flag    = r_sat;

endmodule

// File: tb/tb_csd_stage_ctrl.sv
// Self-checking bench for csd_stage_ctrl at default parameters, with a behavioural CSD
// multiplier attached (unity gain 512, CSD coefficient -363-363j) and a scoreboard.
module tb_csd_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_ready;
  logic [23:0] muestra;
  logic        csd;
  logic [47:0] result;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_ready;
  logic        frame_start;
  logic        sat_flag;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  typedef struct {
    logic [23:0] data;
    logic        fs;
  } exp_t;
  exp_t sb[$];

  int          tb_idx = 0;
  logic        pend_valid = 1'b0;
  logic        pend_csd;
  logic [23:0] pend_data;
  logic        held = 1'b0;
  logic [23:0] held_data;
  logic        held_fs;

  always #5 clk = ~clk;

  csd_stage_ctrl #(.NBITS(12), .NBITScoeff(11), .NPOINTS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .muestra(muestra), .csd(csd), .result(result), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .frame_start(frame_start), .sat_flag(sat_flag)
  );

  function automatic void cmul(input logic [23:0] d, input logic unity, output int pr, output int pi);
    logic signed [11:0] sr;
    logic signed [11:0] si;
    int ar, ai;
    sr = d[23:12];
    si = d[11:0];
    ar = sr;
    ai = si;
    if (unity) begin
      pr = ar * 512;
      pi = ai * 512;
    end else begin
      pr = -363 * ar + 363 * ai;
      pi = -363 * ar - 363 * ai;
    end
  endfunction

  always_comb begin
    int pr, pi;
    cmul(muestra, csd, pr, pi);
    result = {pr[23:0], pi[23:0]};
  end

  function automatic logic [11:0] rq(input int p);
    int q;
    q = (p + 256) >>> 9;
`ifdef CSD_STAGE_CTRL_SAT_EN
    if (q > 2047) q = 2047;
    else if (q < -2048) q = -2048;
`endif
    return q[11:0];
  endfunction

  function automatic logic [23:0] model(input logic [23:0] d, input int idx);
    int pr, pi;
    cmul(d, idx < 4, pr, pi);
    return {rq(pr), rq(pi)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      tb_idx     = 0;
      pend_valid = 1'b0;
      held       = 1'b0;
    end else begin
      if (pend_valid) begin
        check("s1_csd", 32'(csd), 32'(pend_csd));
        check("s1_muestra", 32'(muestra), 32'(pend_data));
        pend_valid = 1'b0;
      end
      if (out_valid) begin
        if (held) begin
          check("stall_data_stable", 32'(out_data), 32'(held_data));
          check("stall_fs_stable", 32'(frame_start), 32'(held_fs));
        end
        if (out_ready) begin
          n_out++;
          check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("frame_start", 32'(frame_start), 32'(e.fs));
          end
          held = 1'b0;
        end else begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          held      = 1'b1;
          held_data = out_data;
          held_fs   = frame_start;
        end
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.data = model(in_data, tb_idx);
        e.fs   = (tb_idx == 0);
        sb.push_back(e);
        pend_valid = 1'b1;
        pend_csd   = (tb_idx < 4);
        pend_data  = in_data;
        tb_idx     = (tb_idx + 1) % 8;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // One sample through an otherwise idle pipe; returns the output and edges taken.
  task automatic send_get(input logic [23:0] d, output logic [23:0] od, output logic ofs, output int lat);
    logic acc = 1'b0;
    logic got = 1'b0;
    od = '0; ofs = 1'b0; lat = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("accept_timeout", 32'(acc), 32'd1);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1; od = out_data; ofs = frame_start; lat = i;
      end else begin
        tick();
      end
    end
    check("output_timeout", 32'(got), 32'd1);
  endtask

  task automatic stream(input int n, input logic [3:0] pat);
    int k = 0;
    int cyc = 0;
    int start_out = n_out;
    logic [23:0] cur = 24'($urandom);
    while (k < n && cyc < 400) begin
      out_ready = pat[cyc % 4];
      in_valid  = 1'b1;
      in_data   = cur;
      @(negedge clk);
      if (in_ready) begin
        k++;
        cur = 24'($urandom);
      end
      cyc++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_accepted", 32'(k), 32'(n));
    for (int i = 0; i < 50 && (sb.size() != 0 || out_valid); i++) tick();
    @(negedge clk);
    check("stream_drained", 32'(sb.size()), 32'd0);
    check("stream_out_count", 32'(n_out - start_out), 32'(n));
  endtask

  initial begin
    logic [23:0] od;
    logic        ofs;
    int          lat;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_rst", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);
    check("rst_muestra", 32'(muestra), 32'd0);
    check("rst_csd", 32'(csd), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("in_ready_idle", 32'(in_ready), 32'd1);

    // Unity path, idx 0: real 100, imag -5
    tick();
    send_get(24'h064FFB, od, ofs, lat);
    check("unity_data", 32'(od), 32'h064FFB);
    check("unity_fs", 32'(ofs), 32'd1);
    check("unity_latency", 32'(lat), 32'd1);

    for (int i = 1; i < 4; i++) begin tick(); send_get(24'(i * 24'h011013), od, ofs, lat); end
    // CSD path, idx 4: real 100, imag 0 -> -71, -71
    tick();
    send_get(24'h064000, od, ofs, lat);
    check("csd_data", 32'(od), 32'hFB9FB9);
    check("csd_fs", 32'(ofs), 32'd0);
    check("no_sat_yet", 32'(sat_flag), 32'd0);

    for (int i = 0; i < 7; i++) begin tick(); send_get(24'h020FF0, od, ofs, lat); end
    // idx 4 again: real 2047, imag -2048
    tick();
    send_get(24'h7FF800, od, ofs, lat);
`ifdef CSD_STAGE_CTRL_SAT_EN
    check("sat_data", 32'(od), 32'h800001);
    check("sat_flag_set", 32'(sat_flag), 32'd1);
`else
    check("wrap_data", 32'(od), 32'h4A9001);
    check("wrap_sat_flag", 32'(sat_flag), 32'd0);
`endif
    tick();
    send_get(24'h010010, od, ofs, lat);
`ifdef CSD_STAGE_CTRL_SAT_EN
    check("sat_flag_sticky", 32'(sat_flag), 32'd1);
`else
    check("wrap_sat_flag_idle", 32'(sat_flag), 32'd0);
`endif

    // Backpressure with out_ready 1,0,0,1 across two frames
    do_reset();
    stream(16, 4'b1001);

    // Index wrap over 9 samples
    do_reset();
    stream(9, 4'b1111);

    // Mid-stream reset with both stages full
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 24'h123456;
    @(negedge clk);
    check("fill_a_ready", 32'(in_ready), 32'd1);
    tick();
    in_data = 24'h654321;
    @(negedge clk);
    check("fill_b_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sat_flag", 32'(sat_flag), 32'd0);
    tick();
    send_get(24'h00A00A, od, ofs, lat);
    check("midrst_fs", 32'(ofs), 32'd1);
    check("midrst_data", 32'(od), 32'h00A00A);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
